// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding instruction bus, one-entry skid buffer,
// branch/trap redirect, and the registered IF/ID pipeline slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        branch_valid,
  input  logic [31:0] branch_pc,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic        if2id_valid,
  output logic [31:0] if2id_pc,
  output logic [31:0] if2id_instruction
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            outstanding_q, outstanding_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            discard_q, discard_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            if2id_valid_q, if2id_valid_d;
  logic [XLEN-1:0] if2id_pc_q, if2id_pc_d;
  logic [XLEN-1:0] if2id_instr_q, if2id_instr_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            fire;
  logic            accept;

  // Bus request side; a response in the same cycle frees the single outstanding slot.
  always_comb begin
    redirect  = trap_valid | branch_valid;
    target    = trap_valid ? trap_pc : branch_pc;
    ibus_req  = ~rst & ~redirect & ~stall & ~skid_valid_q & (~outstanding_q | ibus_rvalid);
    ibus_addr = {pc_q[XLEN-1:2], 2'b00};
    fire      = ibus_req & ibus_gnt;
    // A response with nothing outstanding belongs to a pre-reset request and is ignored.
    accept    = ibus_rvalid & outstanding_q & ~discard_q & ~redirect;
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    out_pc_d      = out_pc_q;
    discard_d     = discard_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if2id_valid_d = if2id_valid_q;
    if2id_pc_d    = if2id_pc_q;
    if2id_instr_d = if2id_instr_q;

    if (fire) begin
      outstanding_d = 1'b1;
      out_pc_d      = pc_q;
      pc_d          = pc_q + XLEN'(4);
    end else if (ibus_rvalid) begin
      outstanding_d = 1'b0;
    end
    if (ibus_rvalid) discard_d = 1'b0;

    if (accept && stall) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = out_pc_q;
      skid_instr_d = ibus_rdata;
    end

    if (!stall) begin
      if (skid_valid_q) begin
        if2id_valid_d = 1'b1;
        if2id_pc_d    = skid_pc_q;
        if2id_instr_d = skid_instr_q;
        skid_valid_d  = 1'b0;
      end else if (accept) begin
        if2id_valid_d = 1'b1;
        if2id_pc_d    = out_pc_q;
        if2id_instr_d = ibus_rdata;
      end else begin
        if2id_valid_d = 1'b0;
      end
    end

    // Redirect overrides stall and flushes everything fetched on the old path.
    if (redirect) begin
      pc_d          = target;
      if2id_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      discard_d     = outstanding_q & ~ibus_rvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      out_pc_q      <= RESET_PC;
      discard_q     <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= RESET_PC;
      skid_instr_q  <= NOP_INSTR;
      if2id_valid_q <= 1'b0;
      if2id_pc_q    <= RESET_PC;
      if2id_instr_q <= NOP_INSTR;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      out_pc_q      <= out_pc_d;
      discard_q     <= discard_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if2id_valid_q <= if2id_valid_d;
      if2id_pc_q    <= if2id_pc_d;
      if2id_instr_q <= if2id_instr_d;
    end
  end

  assign if2id_valid       = if2id_valid_q;
  assign if2id_pc          = if2id_pc_q;
  assign if2id_instruction = if2id_instr_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch (IF) stage of the veriRISCV 5-stage core. Holds the program counter and issues word fetches on a single-outstanding instruction bus, absorbing stalls with a one-entry skid buffer. Applies branch and trap redirects. Drives the registered IF/ID pipeline outputs (`if2id_valid`, `if2id_pc`, `if2id_instruction`) consumed directly by the decode stage.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: value of `if2id_instruction` after reset (`addi x0,x0,0`).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold the IF/ID outputs (from the hazard unit, load dependence).
- `trap_valid` in 1: redirect to `trap_pc` (trap/mret). Has priority over `branch_valid`.
- `trap_pc` in 32: trap target.
- `branch_valid` in 1: redirect to `branch_pc` (taken branch/jal/jalr from EX).
- `branch_pc` in 32: branch target.
- `ibus_req` out 1: fetch request.
- `ibus_addr` out 32: fetch address; bits [1:0] are always 0.
- `ibus_gnt` in 1: request accepted this cycle.
- `ibus_rvalid` in 1: read data valid. Arrives ≥1 cycle after grant; responses are in order.
- `ibus_rdata` in 32: instruction word.
- `if2id_valid` out 1: IF/ID slot holds a valid instruction.
- `if2id_pc` out 32: PC of the slot instruction.
- `if2id_instruction` out 32: instruction word.

## Operation
Internal state:
- `pc_q`: next fetch address.
- `outstanding`, `out_pc`: a granted request awaiting `rvalid`, and its address.
- `discard`: the outstanding response belongs to a flushed path.
- `skid_valid`, `skid_pc`, `skid_instr`: the skid buffer.

Redirect: `redirect = trap_valid | branch_valid`; `target = trap_valid ? trap_pc : branch_pc`.

Request logic:
- `ibus_req = ~rst & ~redirect & ~stall & ~skid_valid & (~outstanding | (ibus_rvalid))`.
- `ibus_addr = {pc_q[31:2], 2'b00}`.

On grant:
- `outstanding <= 1`, `out_pc <= pc_q`, `pc_q <= pc_q + 4` (wraps modulo 2^32).

On `rvalid` with no same-cycle grant:
- `outstanding <= 0`, `discard <= 0`.
- A response with `discard = 1` is dropped silently.

Accepted response (`rvalid & ~discard & ~redirect`):
- If `~stall`: IF/ID takes `{1, out_pc, rdata}`.
- If `stall`: write to the skid buffer (`skid_valid <= 1`).

IF/ID update when `~stall`, in priority order:
- skid (and `skid_valid <= 0`);
- else accepted response;
- else `if2id_valid <= 0`.

IF/ID update when `stall`: hold all outputs.

Redirect, which overrides `stall`:
- `pc_q <= target`, `if2id_valid <= 0`, `skid_valid <= 0`.
- `discard <= outstanding & ~ibus_rvalid`.
- Any response arriving in the redirect cycle is dropped.

Invariants:
- At most one request outstanding.
- The skid buffer never overflows, because no request is issued while `stall` or `skid_valid` is high.
- `stall` and `redirect` together: redirect wins and the slot empties.

Reset values:
- `pc_q = RESET_PC`; `outstanding`, `discard`, `skid_valid` = 0.
- `if2id_valid = 0`, `if2id_pc = RESET_PC`, `if2id_instruction = NOP_INSTR`, `ibus_req = 0`.
- Reset mid-transaction clears `outstanding` and `discard`. The bus must not return a response for a pre-reset request; this is a system requirement, and the block ignores any such response (`outstanding = 0`).

## Timing
- Reset release at cycle 0: `ibus_req` high with `RESET_PC` in cycle 0. With zero-wait bus (`gnt = 1`, `rvalid` at +1), `if2id_valid` is high from cycle 2.
- Zero-wait steady state: one instruction per cycle (request overlaps the `rvalid` cycle).
- Response to IF/ID output: 1 cycle (registered).
- Redirect asserted in cycle N:
  - no request in N;
  - `ibus_addr = target` in N+1;
  - zero-wait: first target instruction valid in N+3;
  - `if2id_valid = 0` from N+1 until then.
- Stall release in cycle M with skid full: skid drives IF/ID at M+1. Requests resume in the cycle after the skid drains.

## Test plan
- Reset, zero-wait bus returning rdata = addr: `if2id_pc` = 0,4,8,… on consecutive cycles from cycle 2, `if2id_instruction` = `if2id_pc`.
- Stall 3 cycles while a response is in flight: IF/ID holds PC 0x8; PC 0xC goes to the skid. After release, 0xC appears, then 0x10. No instruction lost or duplicated.
- `branch_valid`, `branch_pc` = 0x100 while a response (PC 0x14) is outstanding with 3-cycle latency: 0x14 dropped, next `if2id_pc` = 0x100.
- `trap_valid` (`trap_pc` = 0x200) and `branch_valid` (0x100) in the same cycle with `stall` = 1: `if2id_valid` = 0 next cycle, next fetch at 0x200.
- `ibus_gnt` low for 4 cycles: `ibus_req`/`ibus_addr` held stable, `pc_q` unchanged. Then normal fetch at the same address.
- `RESET_PC` = 32'hFFFF_FFFC: fetches 0xFFFF_FFFC, then wraps to 0x0000_0000. `rst` asserted mid-stream: all outputs return to their reset values the next cycle.
